// File: rtl/cu_pkg.sv
// cu_pkg: shared types and encodings for the cu_microseq control unit.
//   - cu_state_e : microsequencer FSM states
//   - OP_*       : 4-bit opcodes (ir[INSTR_W-1 -: 4])
//   - FUN_*      : RF / ARF / IR function encodings
//   - ARF_*      : ARF output-select indices and one-hot write enables
//   - MUX_*      : MuxA / MuxB input selects
//   - ALU_*      : ALU function codes
//   - REG_BASE   : field value that names R1 (R1..RNREG = REG_BASE..REG_BASE+NREG-1)
package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } cu_state_e;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_NOT = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_LSR = 4'h5;
    localparam logic [3:0] OP_LSL = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_DEC = 4'h8;
    localparam logic [3:0] OP_BRA = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hA;
    localparam logic [3:0] OP_MOV = 4'hB;
    localparam logic [3:0] OP_LD  = 4'hC;
    localparam logic [3:0] OP_ST  = 4'hD;
    localparam logic [3:0] OP_PUL = 4'hE;
    localparam logic [3:0] OP_PSH = 4'hF;

    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    localparam logic [1:0] ARF_AR  = 2'b00;
    localparam logic [1:0] ARF_SP  = 2'b01;
    localparam logic [1:0] ARF_PCP = 2'b10;
    localparam logic [1:0] ARF_PC  = 2'b11;

    // arf_rsel bit order is {AR, SP, PCpast, PC}
    localparam logic [3:0] ARF_EN_AR  = 4'b1000;
    localparam logic [3:0] ARF_EN_SP  = 4'b0100;
    localparam logic [3:0] ARF_EN_PCP = 4'b0010;
    localparam logic [3:0] ARF_EN_PC  = 4'b0001;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IRL = 2'b10;
    localparam logic [1:0] MUX_ARF = 2'b11;

    localparam logic [3:0] ALU_PASSA = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b0001;
    localparam logic [3:0] ALU_NOT   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0101;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_LSL   = 4'b1011;
    localparam logic [3:0] ALU_LSR   = 4'b1100;

    localparam int REG_BASE = 4;

endpackage

// File: rtl/cu_onehot_dec.sv
// cu_onehot_dec: N-to-2^N one-hot decoder (out_o[k] = 1 when in_i == k).
//   in_i  [N-1:0]      binary index
//   out_o [2^N-1:0]    one-hot result
module cu_onehot_dec #(
    parameter int N = 4
) (
    input  logic [N-1:0]        in_i,
    output logic [(1<<N)-1:0]   out_o
);

    always_comb begin
        out_o       = '0;
        out_o[in_i] = 1'b1;
    end

endmodule

// File: rtl/cu_microseq.sv
// cu_microseq: hardwired microsequencer driving ALU_System.
// FSM: IDLE -> FETCH_L -> FETCH_H -> DECODE -> EXEC -> FETCH_L ...; HALT on
// memory timeout (or HLT when built with CU_HALT_OPC_EN).
//
// Instruction fields (INSTR_W >= 16):
//   [INSTR_W-1 -: 4] opcode
//   reg/ALU ops : [11:8] source A, [7:4] destination, [3:0] source B
//   memory ops  : [11:8] register, [7:0] address (loaded into AR in DECODE)
//   register field value REG_BASE+k names R(k+1); other values are not registers
//
// Memory handshake: mem_cs_o=0 presents an access; it completes in the cycle
// mem_ready_i=1. Until then every drive is held and no ARF/RF write is issued.
// WAIT_MAX consecutive not-ready cycles abort to HALT with bus_err_o set.
//
// Ports: clk, rst_n (async active-low); start_i, ir_i, alu_z_i, mem_ready_i in;
// datapath selects/functions/enables out; mem_cs_o (active low), mem_wr_o;
// busy_o, bus_err_o (sticky); state_o exposes the FSM state.
//
// Build option: CU_HALT_OPC_EN makes 16'hFFFF a HLT instruction.
module cu_microseq
    import cu_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int NREG     = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [INSTR_W-1:0] ir_i,
    input  logic               alu_z_i,
    input  logic               mem_ready_i,
    output logic [1:0]         mux_a_sel_o,
    output logic [1:0]         mux_b_sel_o,
    output logic               mux_c_sel_o,
    output logic [2:0]         rf_outa_sel_o,
    output logic [2:0]         rf_outb_sel_o,
    output logic [1:0]         rf_funsel_o,
    output logic [NREG-1:0]    rf_rsel_o,
    output logic [3:0]         alu_funsel_o,
    output logic [1:0]         arf_outa_sel_o,
    output logic [1:0]         arf_outb_sel_o,
    output logic [1:0]         arf_funsel_o,
    output logic [3:0]         arf_rsel_o,
    output logic [1:0]         ir_funsel_o,
    output logic               ir_en_o,
    output logic               ir_lh_o,
    output logic               mem_cs_o,
    output logic               mem_wr_o,
    output logic               busy_o,
    output logic               bus_err_o,
    output cu_state_e          state_o
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    cu_state_e          state_q, state_d;
    logic               bus_err_q, bus_err_d;
    logic [WCNT_W-1:0]  wait_q, wait_d;

    logic [3:0]  opcode, dst_f;
    logic [15:0] op_dec, dst_dec, srca_dec, srcb_dec;
    logic        hlt_op, psh_op, mem_op, mem_access, timeout;
    logic        dst_ok, srca_ok, srcb_ok, bin_op, un_op;
    logic [3:0]  alu_fn;
    logic [NREG-1:0] rsel_dst;
    logic        unused_dec;

    assign opcode = ir_i[INSTR_W-1 -: 4];

`ifdef CU_HALT_OPC_EN
    assign hlt_op = op_dec[OP_PSH] && (ir_i[11:0] == 12'hFFF);
`else
    assign hlt_op = 1'b0;
`endif
    assign psh_op = op_dec[OP_PSH] & ~hlt_op;
    assign mem_op = op_dec[OP_LD] | op_dec[OP_ST] | op_dec[OP_PUL] | psh_op;
    assign dst_f  = mem_op ? ir_i[11:8] : ir_i[7:4];

    cu_onehot_dec #(.N(4)) u_op_dec   (.in_i(opcode),     .out_o(op_dec));
    cu_onehot_dec #(.N(4)) u_dst_dec  (.in_i(dst_f),      .out_o(dst_dec));
    cu_onehot_dec #(.N(4)) u_srca_dec (.in_i(ir_i[11:8]), .out_o(srca_dec));
    cu_onehot_dec #(.N(4)) u_srcb_dec (.in_i(ir_i[3:0]),  .out_o(srcb_dec));

    // Only the REG_BASE window of each field decoder names a register.
    assign unused_dec = ^{dst_dec, srca_dec, srcb_dec};
    assign dst_ok  = |dst_dec[REG_BASE +: NREG];
    assign srca_ok = |srca_dec[REG_BASE +: NREG];
    assign srcb_ok = |srcb_dec[REG_BASE +: NREG];

    // rf_rsel is MSB-first: R1 is the top bit.
    always_comb begin
        rsel_dst = '0;
        for (int k = 0; k < NREG; k++) begin
            rsel_dst[NREG-1-k] = dst_dec[REG_BASE+k];
        end
    end

    assign bin_op = op_dec[OP_AND] | op_dec[OP_OR] | op_dec[OP_ADD] | op_dec[OP_SUB];
    assign un_op  = op_dec[OP_NOT] | op_dec[OP_LSR] | op_dec[OP_LSL] | op_dec[OP_MOV];
    assign alu_fn = ({4{op_dec[OP_AND]}} & ALU_AND) | ({4{op_dec[OP_OR]}}  & ALU_OR)
                  | ({4{op_dec[OP_NOT]}} & ALU_NOT) | ({4{op_dec[OP_ADD]}} & ALU_ADD)
                  | ({4{op_dec[OP_SUB]}} & ALU_SUB) | ({4{op_dec[OP_LSR]}} & ALU_LSR)
                  | ({4{op_dec[OP_LSL]}} & ALU_LSL) | ({4{op_dec[OP_MOV]}} & ALU_PASSB);

    assign mem_access = (state_q == ST_FETCH_L) || (state_q == ST_FETCH_H)
                     || ((state_q == ST_EXEC) && mem_op);
    // A ready in the final allowed cycle completes the access instead of timing out.
    assign timeout = mem_access && !mem_ready_i && (wait_q == WCNT_W'(WAIT_MAX - 1));
    assign wait_d  = (mem_access && !mem_ready_i && !timeout) ? wait_q + WCNT_W'(1) : '0;

    always_comb begin
        state_d        = state_q;
        bus_err_d      = bus_err_q;
        mux_a_sel_o    = MUX_ALU;
        mux_b_sel_o    = MUX_ALU;
        mux_c_sel_o    = 1'b0;      // ALU A always takes RF outA
        rf_outa_sel_o  = 3'b000;
        rf_outb_sel_o  = 3'b000;
        rf_funsel_o    = FUN_CLR;
        rf_rsel_o      = '0;
        alu_funsel_o   = ALU_PASSA;
        arf_outa_sel_o = ARF_AR;
        arf_outb_sel_o = ARF_AR;
        arf_funsel_o   = FUN_CLR;
        arf_rsel_o     = 4'b0000;
        ir_funsel_o    = FUN_CLR;
        ir_en_o        = 1'b0;
        ir_lh_o        = 1'b0;
        mem_cs_o       = 1'b1;
        mem_wr_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH_L;
            end
            ST_FETCH_L, ST_FETCH_H: begin
                mem_cs_o       = 1'b0;
                arf_outb_sel_o = ARF_PC;
                ir_en_o        = 1'b1;
                ir_funsel_o    = FUN_LOAD;
                ir_lh_o        = (state_q == ST_FETCH_H);
                if (mem_ready_i) begin
                    arf_funsel_o = FUN_INC;
                    arf_rsel_o   = ARF_EN_PC | ARF_EN_PCP;
                    state_d      = (state_q == ST_FETCH_L) ? ST_FETCH_H : ST_DECODE;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                mux_b_sel_o  = MUX_IRL;
                arf_funsel_o = FUN_LOAD;
                arf_rsel_o   = ARF_EN_AR;
                state_d      = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH_L;
                if (mem_op) begin
                    mem_cs_o = 1'b0;
                    if (op_dec[OP_LD] || op_dec[OP_PUL]) begin
                        arf_outb_sel_o = op_dec[OP_LD] ? ARF_AR : ARF_SP;
                        mux_a_sel_o    = MUX_MEM;
                        rf_funsel_o    = FUN_LOAD;
                        if (mem_ready_i && dst_ok) rf_rsel_o = rsel_dst;
                        if (mem_ready_i && op_dec[OP_PUL]) begin
                            arf_funsel_o = FUN_INC;
                            arf_rsel_o   = ARF_EN_SP;
                        end
                    end else begin
                        arf_outb_sel_o = op_dec[OP_ST] ? ARF_AR : ARF_SP;
                        rf_outa_sel_o  = dst_f[2:0];
                        alu_funsel_o   = ALU_PASSA;
                        mem_wr_o       = 1'b1;
                        if (mem_ready_i && psh_op) begin
                            arf_funsel_o = FUN_DEC;
                            arf_rsel_o   = ARF_EN_SP;
                        end
                    end
                    if (!mem_ready_i) begin
                        state_d = ST_EXEC;
                        if (timeout) begin
                            state_d   = ST_HALT;
                            bus_err_d = 1'b1;
                        end
                    end
                end else if (hlt_op) begin
                    state_d = ST_HALT;
                end else if (op_dec[OP_BRA] || op_dec[OP_BNE]) begin
                    arf_outa_sel_o = ARF_AR;
                    mux_b_sel_o    = MUX_ARF;
                    arf_funsel_o   = FUN_LOAD;
                    if (op_dec[OP_BRA] || !alu_z_i) arf_rsel_o = ARF_EN_PC;
                end else if (op_dec[OP_INC] || op_dec[OP_DEC]) begin
                    rf_funsel_o = op_dec[OP_INC] ? FUN_INC : FUN_DEC;
                    if (dst_ok) rf_rsel_o = rsel_dst;
                end else begin
                    rf_outa_sel_o = ir_i[10:8];
                    rf_outb_sel_o = ir_i[2:0];
                    alu_funsel_o  = alu_fn;
                    mux_a_sel_o   = MUX_ALU;
                    rf_funsel_o   = FUN_LOAD;
                    if ((bin_op && dst_ok && srca_ok && srcb_ok) || (un_op && dst_ok && srcb_ok))
                        rf_rsel_o = rsel_dst;
                end
            end
            ST_HALT: begin
                if (start_i) begin
                    state_d   = ST_FETCH_L;
                    bus_err_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign bus_err_o = bus_err_q;
    assign state_o   = state_q;

endmodule
